// File: rtl/fi_mem_pkg.sv
// Shared types and limits for the fi_mem_responder memory model and its response queue.
package fi_mem_pkg;

  localparam int MAX_LATENCY     = 7;
  localparam int MAX_OUTSTANDING = 4;
  localparam int CD_W            = 3;

  typedef struct packed {
    logic [31:0]     rdata;
    logic            error;
    logic [CD_W-1:0] countdown;
  } resp_entry_t;

  // One cycle of ageing: countdown decrements and sticks at zero.
  function automatic resp_entry_t entry_age(input resp_entry_t e);
    resp_entry_t r;
    r = e;
    if (r.countdown != '0) begin
      r.countdown = r.countdown - 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fi_mem_resp_queue.sv
// In-order pending-response queue; slot 0 is always the head, every entry ages each cycle.
module fi_mem_resp_queue
  import fi_mem_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        push_i,
  input  resp_entry_t push_entry_i,
  input  logic        pop_i,
  output logic        full_o,
  output logic        empty_o,
  output logic        head_valid_o,
  output resp_entry_t head_o
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic [CNT_W-1:0] tail_idx;
  logic             do_push;
  logic             do_pop;
  resp_entry_t      slot_q [DEPTH];
  resp_entry_t      slot_d [DEPTH];

  assign full_o       = (count_q == CNT_W'(DEPTH));
  assign empty_o      = (count_q == '0);
  assign head_o       = slot_q[0];
  assign head_valid_o = ~empty_o && (slot_q[0].countdown == '0);
  assign do_push      = push_i & ~full_o;
  assign do_pop       = pop_i & head_valid_o;
  // The pushed entry lands just behind the survivors of this cycle's pop.
  assign tail_idx     = count_q - CNT_W'(do_pop);
  assign count_d      = count_q + CNT_W'(do_push) - CNT_W'(do_pop);

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      slot_d[i] = entry_age(slot_q[i]);
      if (do_pop) begin
        if (i < DEPTH - 1) begin
          slot_d[i] = entry_age(slot_q[(i + 1) % DEPTH]);
        end else begin
          slot_d[i] = '0;
        end
      end
      if (do_push && (tail_idx == CNT_W'(i))) begin
        slot_d[i] = push_entry_i;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        slot_q[i] <= '0;
      end
    end else begin
      count_q <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        slot_q[i] <= slot_d[i];
      end
    end
  end

endmodule

// File: rtl/fi_mem_responder.sv
// Fixed-latency memory responder for a core's req/gnt/recv/ack port.
// Define FI_MEM_ERROR_EN to flag out-of-range accesses as bus errors instead of wrapping.
module fi_mem_responder
  import fi_mem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          MEM_WORDS   = 256,
  parameter int          LATENCY     = 2,
  parameter int          OUTSTANDING = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mem_req,
  input  logic        mem_wen,
  input  logic [3:0]  mem_strb,
  input  logic [31:0] mem_wdata,
  input  logic [31:0] mem_addr,
  output logic        mem_gnt,
  output logic        mem_recv,
  input  logic        mem_ack,
  output logic        mem_error,
  output logic [31:0] mem_rdata
);

  localparam int AW = $clog2(MEM_WORDS);

  logic [31:0]   mem_q [MEM_WORDS];
  logic [31:0]   offset;
  logic [AW-1:0] word_idx;
  logic          in_range;
  logic          req_err;
  logic          accept;
  logic          wr_en;
  logic [3:0]    lane_we;
  logic          q_full;
  logic          q_empty;
  logic          q_head_valid;
  resp_entry_t   q_head;
  resp_entry_t   push_entry;
  logic          unused_sig;

  assign offset   = mem_addr - BASE_ADDR;
  assign word_idx = offset[AW+1:2];
  assign in_range = (offset < 32'(4 * MEM_WORDS));

`ifdef FI_MEM_ERROR_EN
  assign req_err = ~in_range;
`else
  assign req_err = 1'b0;
`endif

  // Grant sees only registered occupancy, so a same-cycle pop never frees a slot.
  assign mem_gnt = mem_req & ~q_full & ~reset;
  assign accept  = mem_gnt;
  assign wr_en   = accept & mem_wen & ~req_err;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign lane_we[gi] = wr_en & mem_strb[gi];
  end

  always_ff @(posedge clock) begin
    for (int b = 0; b < 4; b++) begin
      if (lane_we[b]) begin
        mem_q[word_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

  // Read data is captured into the queue entry at accept time.
  always_comb begin
    push_entry           = '0;
    push_entry.error     = req_err;
    push_entry.countdown = CD_W'(LATENCY - 1);
    if (!mem_wen && !req_err) begin
      push_entry.rdata = mem_q[word_idx];
    end
  end

  fi_mem_resp_queue #(
    .DEPTH(OUTSTANDING)
  ) u_queue (
    .clock       (clock),
    .reset       (reset),
    .push_i      (accept),
    .push_entry_i(push_entry),
    .pop_i       (mem_ack & ~reset),
    .full_o      (q_full),
    .empty_o     (q_empty),
    .head_valid_o(q_head_valid),
    .head_o      (q_head)
  );

  assign mem_recv  = q_head_valid & ~reset;
  assign mem_rdata = mem_recv ? q_head.rdata : 32'h0;

`ifdef FI_MEM_ERROR_EN
  assign mem_error = mem_recv & q_head.error;
`else
  assign mem_error = 1'b0;
`endif

  assign unused_sig = ^{offset[1:0], offset[31:AW+2], in_range, q_empty,
                        q_head.error, q_head.countdown};

endmodule

// File: tb/tb_fi_mem_responder.sv
// Directed bench for fi_mem_responder (default LATENCY=2, OUTSTANDING=2, MEM_WORDS=256).
module tb_fi_mem_responder;

  logic        clock = 1'b0;
  logic        reset;
  logic        mem_req, mem_wen, mem_ack;
  logic [3:0]  mem_strb;
  logic [31:0] mem_wdata, mem_addr;
  logic        mem_gnt, mem_recv, mem_error;
  logic [31:0] mem_rdata;

  logic        b_req, b_wen, b_ack;
  logic [3:0]  b_strb;
  logic [31:0] b_wdata, b_addr;
  logic        b_gnt, b_recv, b_error;
  logic [31:0] b_rdata;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  fi_mem_responder u_dut (
    .clock(clock), .reset(reset), .mem_req(mem_req), .mem_wen(mem_wen),
    .mem_strb(mem_strb), .mem_wdata(mem_wdata), .mem_addr(mem_addr),
    .mem_gnt(mem_gnt), .mem_recv(mem_recv), .mem_ack(mem_ack),
    .mem_error(mem_error), .mem_rdata(mem_rdata)
  );

  // Deeper queue instance so three back-to-back reads are never throttled.
  fi_mem_responder #(.OUTSTANDING(3)) u_dut_b2b (
    .clock(clock), .reset(reset), .mem_req(b_req), .mem_wen(b_wen),
    .mem_strb(b_strb), .mem_wdata(b_wdata), .mem_addr(b_addr),
    .mem_gnt(b_gnt), .mem_recv(b_recv), .mem_ack(b_ack),
    .mem_error(b_error), .mem_rdata(b_rdata)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic smp();
    @(negedge clock);
  endtask

  task automatic set_req(input logic wen, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] strb);
    mem_req = 1'b1; mem_wen = wen; mem_addr = addr; mem_wdata = wdata; mem_strb = strb;
  endtask

  task automatic test_reset();
    reset = 1'b1; mem_req = 1'b1; mem_wen = 1'b0; mem_addr = 32'h0; mem_ack = 1'b1;
    step(); step(); smp();
    checks++; if (mem_gnt !== 1'b0) begin errors++; $display("FAIL rst_gnt: got %b want 0", mem_gnt); end
    checks++; if (mem_recv !== 1'b0) begin errors++; $display("FAIL rst_recv: got %b want 0", mem_recv); end
    checks++; if (mem_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h want 0", mem_rdata); end
    checks++; if (mem_error !== 1'b0) begin errors++; $display("FAIL rst_error: got %b want 0", mem_error); end
    step(); reset = 1'b0; mem_req = 1'b0;
    smp();
    checks++; if (mem_recv !== 1'b0) begin errors++; $display("FAIL rst_recv_after: got %b want 0", mem_recv); end
    $display("[%0d] reset done", cyc);
  endtask

  // Write then read at the same address; responses at N+2 and N+3.
  task automatic wr_rd(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] strb, input logic [31:0] rd_addr,
                       input logic [31:0] exp_rdata, input logic exp_err);
    step(); mem_ack = 1'b1; set_req(1'b1, addr, wdata, strb);
    smp();
    checks++; if (mem_gnt !== 1'b1) begin errors++; $display("FAIL %s_wr_gnt: got %b want 1", tag, mem_gnt); end
    $display("[%0d] %s WR addr=%h data=%h strb=%b", cyc, tag, addr, wdata, strb);
    step(); set_req(1'b0, rd_addr, 32'h0, 4'h0);
    smp();
    checks++; if (mem_gnt !== 1'b1) begin errors++; $display("FAIL %s_rd_gnt: got %b want 1", tag, mem_gnt); end
    checks++; if (mem_recv !== 1'b0) begin errors++; $display("FAIL %s_early_recv: got %b want 0", tag, mem_recv); end
    $display("[%0d] %s RD addr=%h", cyc, tag, rd_addr);
    step(); mem_req = 1'b0;
    smp();
    checks++; if (mem_recv !== 1'b1 || mem_rdata !== 32'h0 || mem_error !== 1'b0) begin
      errors++; $display("FAIL %s_wr_resp: got recv=%b rdata=%h err=%b want 1/0/0", tag, mem_recv, mem_rdata, mem_error); end
    $display("[%0d] %s WR resp", cyc, tag);
    step(); smp();
    checks++; if (mem_recv !== 1'b1 || mem_rdata !== exp_rdata || mem_error !== exp_err) begin
      errors++; $display("FAIL %s_rd_resp: got recv=%b rdata=%h err=%b want 1/%h/%b", tag, mem_recv, mem_rdata, mem_error, exp_rdata, exp_err); end
    $display("[%0d] %s RD resp rdata=%h err=%b", cyc, tag, mem_rdata, mem_error);
    step(); smp();
    checks++; if (mem_recv !== 1'b0) begin errors++; $display("FAIL %s_idle: got recv=%b want 0", tag, mem_recv); end
  endtask

  task automatic test_write_read();
    wr_rd("full", 32'h10, 32'hDEADBEEF, 4'hF, 32'h10, 32'hDEADBEEF, 1'b0);
  endtask

  task automatic test_strobe();
    wr_rd("strb", 32'h10, 32'h000000AA, 4'b0001, 32'h10, 32'hDEADBEAA, 1'b0);
  endtask

  task automatic test_backpressure();
    int n;
    step(); mem_ack = 1'b0; set_req(1'b0, 32'h10, 32'h0, 4'h0);
    smp();
    checks++; if (mem_gnt !== 1'b1) begin errors++; $display("FAIL bp_gnt0: got %b want 1", mem_gnt); end
    step(); smp();
    checks++; if (mem_gnt !== 1'b1) begin errors++; $display("FAIL bp_gnt1: got %b want 1", mem_gnt); end
    step(); smp();
    checks++; if (mem_gnt !== 1'b0) begin errors++; $display("FAIL bp_full: got gnt=%b want 0", mem_gnt); end
    checks++; if (mem_recv !== 1'b1 || mem_rdata !== 32'hDEADBEAA) begin
      errors++; $display("FAIL bp_hold0: got recv=%b rdata=%h want 1/deadbeaa", mem_recv, mem_rdata); end
    step(); smp();
    checks++; if (mem_gnt !== 1'b0 || mem_recv !== 1'b1 || mem_rdata !== 32'hDEADBEAA) begin
      errors++; $display("FAIL bp_hold1: got gnt=%b recv=%b rdata=%h want 0/1/deadbeaa", mem_gnt, mem_recv, mem_rdata); end
    step(); mem_ack = 1'b1; smp();
    checks++; if (mem_gnt !== 1'b0 || mem_recv !== 1'b1) begin
      errors++; $display("FAIL bp_ack_cycle: got gnt=%b recv=%b want 0/1", mem_gnt, mem_recv); end
    $display("[%0d] bp ACK", cyc);
    step(); mem_ack = 1'b0; smp();
    checks++; if (mem_gnt !== 1'b1) begin errors++; $display("FAIL bp_regrant: got %b want 1", mem_gnt); end
    step(); mem_req = 1'b0; mem_ack = 1'b1;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      smp();
      if (mem_recv) begin
        n++;
        checks++; if (mem_rdata !== 32'hDEADBEAA) begin errors++; $display("FAIL bp_drain_data: got %h want deadbeaa", mem_rdata); end
        $display("[%0d] bp RD resp rdata=%h", cyc, mem_rdata);
      end
      step();
    end
    checks++; if (n != 2) begin errors++; $display("FAIL bp_drain_count: got %0d want 2", n); end
  endtask

  task automatic test_range();
`ifdef FI_MEM_ERROR_EN
    wr_rd("range", 32'h0, 32'h12345678, 4'hF, 32'h400, 32'h0, 1'b1);
`else
    wr_rd("range", 32'h0, 32'h12345678, 4'hF, 32'h400, 32'h12345678, 1'b0);
`endif
  endtask

  task automatic test_reset_midop();
    int n;
    step(); mem_ack = 1'b0; set_req(1'b0, 32'h0, 32'h0, 4'h0);
    smp();
    checks++; if (mem_gnt !== 1'b1) begin errors++; $display("FAIL mid_gnt0: got %b want 1", mem_gnt); end
    step(); smp();
    checks++; if (mem_gnt !== 1'b1) begin errors++; $display("FAIL mid_gnt1: got %b want 1", mem_gnt); end
    step(); mem_req = 1'b0; reset = 1'b1; smp();
    checks++; if (mem_recv !== 1'b0 || mem_rdata !== 32'h0) begin
      errors++; $display("FAIL mid_in_reset: got recv=%b rdata=%h want 0/0", mem_recv, mem_rdata); end
    $display("[%0d] mid-op reset", cyc);
    step(); reset = 1'b0; mem_ack = 1'b1;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      smp();
      if (mem_recv) n++;
      step();
    end
    checks++; if (n != 0) begin errors++; $display("FAIL mid_stale: got %0d responses want 0", n); end
    set_req(1'b0, 32'h0, 32'h0, 4'h0);
    smp();
    checks++; if (mem_gnt !== 1'b1) begin errors++; $display("FAIL mid_rd_gnt: got %b want 1", mem_gnt); end
    step(); mem_req = 1'b0; smp();
    checks++; if (mem_recv !== 1'b0) begin errors++; $display("FAIL mid_rd_early: got %b want 0", mem_recv); end
    step(); smp();
    checks++; if (mem_recv !== 1'b1 || mem_rdata !== 32'h12345678) begin
      errors++; $display("FAIL mid_rd_resp: got recv=%b rdata=%h want 1/12345678", mem_recv, mem_rdata); end
    $display("[%0d] mid RD resp rdata=%h", cyc, mem_rdata);
    step();
  endtask

  task automatic test_back_to_back();
    logic [31:0] wv [3];
    wv[0] = 32'hA1A2A3A4; wv[1] = 32'hB1B2B3B4; wv[2] = 32'hC1C2C3C4;
    step(); b_ack = 1'b1;
    for (int k = 0; k < 3; k++) begin
      b_req = 1'b1; b_wen = 1'b1; b_strb = 4'hF; b_addr = 32'(4 * k); b_wdata = wv[k];
      smp();
      checks++; if (b_gnt !== 1'b1) begin errors++; $display("FAIL b2b_wr_gnt%0d: got %b want 1", k, b_gnt); end
      $display("[%0d] b2b WR addr=%h data=%h", cyc, b_addr, b_wdata);
      step();
    end
    b_req = 1'b0;
    repeat (4) step();
    for (int k = 0; k < 3; k++) begin
      b_req = 1'b1; b_wen = 1'b0; b_addr = 32'(4 * k);
      smp();
      checks++; if (b_gnt !== 1'b1) begin errors++; $display("FAIL b2b_rd_gnt%0d: got %b want 1", k, b_gnt); end
      $display("[%0d] b2b RD addr=%h", cyc, b_addr);
      if (k == 2) begin
        checks++; if (b_recv !== 1'b1 || b_rdata !== wv[0]) begin
          errors++; $display("FAIL b2b_resp0: got recv=%b rdata=%h want 1/%h", b_recv, b_rdata, wv[0]); end
      end
      step();
    end
    b_req = 1'b0;
    smp();
    checks++; if (b_recv !== 1'b1 || b_rdata !== wv[1]) begin
      errors++; $display("FAIL b2b_resp1: got recv=%b rdata=%h want 1/%h", b_recv, b_rdata, wv[1]); end
    step(); smp();
    checks++; if (b_recv !== 1'b1 || b_rdata !== wv[2]) begin
      errors++; $display("FAIL b2b_resp2: got recv=%b rdata=%h want 1/%h", b_recv, b_rdata, wv[2]); end
    step(); smp();
    checks++; if (b_recv !== 1'b0) begin errors++; $display("FAIL b2b_idle: got %b want 0", b_recv); end
    $display("[%0d] b2b responses done", cyc);
  endtask

  initial begin
    mem_wdata = 32'h0; mem_strb = 4'h0;
    b_req = 1'b0; b_wen = 1'b0; b_ack = 1'b1; b_strb = 4'h0; b_wdata = 32'h0; b_addr = 32'h0;
    test_reset();
    test_write_read();
    test_strobe();
    test_backpressure();
    test_range();
    test_reset_midop();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/fi_mem_responder.md
FI_MEM_RESPONDER -- requirements
Module: fi_mem_responder

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_0000: byte address of memory word 0.
REQ-002 Parameter MEM_WORDS, default 256: number of 32-bit words; power of two, 4..4096.
REQ-003 Parameter LATENCY, default 2: cycles from request acceptance to earliest response; range 1..7.
REQ-004 Parameter OUTSTANDING, default 2: pending-response queue depth; range 1..4.
REQ-005 clock  in  1  single clock; all state updates on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 mem_req  in  1  core starts request; held with its payload until granted.
REQ-008 mem_wen  in  1  1 = write, 0 = read.
REQ-009 mem_strb  in  4  byte write strobes; bit i enables byte lane i.
REQ-010 mem_wdata  in  32  write data.
REQ-011 mem_addr  in  32  byte address; bits [1:0] are ignored.
REQ-012 mem_gnt  out  1  request accepted this cycle.
REQ-013 mem_recv  out  1  response valid.
REQ-014 mem_ack  in  1  core accepts response.
REQ-015 mem_error  out  1  response carries a bus error.
REQ-016 mem_rdata  out  32  read data of response.

Function
REQ-017 mem_gnt SHALL equal mem_req AND queue-not-full, combinationally; a pop in the same cycle SHALL NOT free a slot for that cycle's grant.
REQ-018 A request SHALL be accepted exactly on cycles with mem_req=1 and mem_gnt=1.
REQ-019 Word index SHALL be (mem_addr - BASE_ADDR) >> 2, computed modulo 2^32.
REQ-020 An address is in range when (mem_addr - BASE_ADDR) < 4*MEM_WORDS.
REQ-021 An accepted in-range write SHALL update only the byte lanes selected by mem_strb, at the end of the accept cycle.
REQ-022 An accepted in-range read SHALL sample the word at the accept cycle, so a write accepted earlier is always visible to it.
REQ-023 Each accepted request SHALL push one entry {rdata, error, countdown=LATENCY-1} onto the tail of the queue; write entries carry rdata=0.
REQ-024 Every entry's countdown SHALL decrement once per cycle, saturating at 0.
REQ-025 mem_recv SHALL be 1 when the queue is non-empty and the head countdown is 0; responses are in strict acceptance order.
REQ-026 Accept at cycle N SHALL give earliest mem_recv=1 at cycle N+LATENCY.
REQ-027 While mem_recv=1 and mem_ack=0, mem_rdata and mem_error SHALL hold stable.
REQ-028 The head SHALL pop on mem_recv=1 and mem_ack=1; mem_ack with mem_recv=0 SHALL be ignored.
REQ-029 A simultaneous push and pop SHALL leave occupancy unchanged and preserve order.
REQ-030 When mem_recv=0, mem_rdata and mem_error SHALL be 0.

Reset
REQ-031 While reset=1, the queue SHALL empty, and mem_gnt, mem_recv, mem_error and mem_rdata SHALL be 0.
REQ-032 Reset mid-operation SHALL drop all pending responses with no further mem_recv for them.
REQ-033 Memory array contents SHALL NOT be reset; writes SHALL be suppressed while reset=1.

Configuration
REQ-034 Macro FI_MEM_ERROR_EN defined: out-of-range requests SHALL perform no write and respond with error=1, rdata=0.
REQ-035 FI_MEM_ERROR_EN undefined: word index SHALL wrap modulo MEM_WORDS, and mem_error SHALL be constant 0.

Structure
REQ-036 Package fi_mem_pkg SHALL hold the queue-entry struct typedef (rdata, error, countdown[2:0]) and the maximum LATENCY/OUTSTANDING constants.
REQ-037 The response queue SHALL be a sub-module fi_mem_resp_queue (push/pop/full/empty/head, per-entry countdown).
REQ-038 The memory array and address decode SHALL stay in fi_mem_responder.

Verification
REQ-039 Write 0xDEADBEEF to 0x10 with strb=4'hF (accept cycle N), then read 0x10 -> write response at N+2, read response rdata=0xDEADBEEF, error=0.
REQ-040 Write 0x000000AA to 0x10 with strb=4'b0001 over 0xDEADBEEF, then read -> rdata=0xDEADBEAA.
REQ-041 Hold mem_req=1 with mem_ack=0, OUTSTANDING=2 -> two grants, then mem_gnt=0; mem_recv held, rdata stable; one ack -> mem_gnt returns the next cycle.
REQ-042 Read 0x400 with MEM_WORDS=256 -> with FI_MEM_ERROR_EN, error=1 and rdata=0; without it, rdata equals the word at 0x000.
REQ-043 Assert reset for one cycle with two responses pending -> mem_recv=0 after reset, with no stale response; the next read returns current memory.
REQ-044 Back-to-back reads of 0x0, 0x4, 0x8 with mem_ack=1 throughout -> three responses in order on consecutive cycles starting N+LATENCY.
